// File: rtl/regfile_seq.sv
// Instruction sequencer driving the 8x16 register file: accept, read operands, write back, pulse done.
// Optional SUB instruction (101/01) is enabled by defining REGFILE_SEQ_SUB_EN.
module regfile_seq #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] instr,
  output logic [2:0]    rf_readnum,
  input  logic [DW-1:0] rf_data_out,
  output logic [2:0]    rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state_o
);

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and the source holds instr/in_valid until then.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READA = 3'd1,
    S_READB = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    K_MOVI = 2'd0,
    K_MOVR = 2'd1,
    K_ALU  = 2'd2,
    K_BAD  = 2'd3
  } kind_t;

  state_t        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          err_q, err_d;
  logic [DW-1:0] result;
  logic          unused_bits;

  function automatic kind_t classify(input logic [15:0] i);
    case ({i[15:13], i[12:11]})
      5'b110_10: classify = K_MOVI;
      5'b110_00: classify = K_MOVR;
      5'b101_00: classify = K_ALU;
`ifdef REGFILE_SEQ_SUB_EN
      5'b101_01: classify = K_ALU;
`endif
      default:   classify = K_BAD;
    endcase
  endfunction

  assign unused_bits = ^instr_q[4:3];
  assign dbg_state_o = state_q;

  // Result is built only from latched instruction and operands.
  always_comb begin
    result = '0;
    case (classify(instr_q))
      K_MOVI:  result = {{8{instr_q[7]}}, instr_q[7:0]};
      K_MOVR:  result = b_q;
`ifdef REGFILE_SEQ_SUB_EN
      K_ALU:   result = instr_q[11] ? (a_q - b_q) : (a_q + b_q);
`else
      K_ALU:   result = a_q + b_q;
`endif
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    a_d         = a_q;
    b_d         = b_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    rf_readnum  = 3'd0;
    rf_writenum = 3'd0;
    rf_write    = 1'b0;
    rf_data_in  = '0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          instr_d = instr[15:0];
          err_d   = 1'b0;
          case (classify(instr[15:0]))
            K_MOVI:  state_d = S_WRITE;
            K_MOVR:  state_d = S_READB;
            K_ALU:   state_d = S_READA;
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_READA: begin
        rf_readnum = instr_q[10:8];
        a_d        = rf_data_out;
        state_d    = S_READB;
      end
      S_READB: begin
        rf_readnum = instr_q[2:0];
        b_d        = rf_data_out;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        // Gate with reset so an aborted instruction never commits.
        rf_write    = !reset;
        rf_writenum = (classify(instr_q) == K_MOVI) ? instr_q[10:8] : instr_q[7:5];
        rf_data_in  = result;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

endmodule
